// File: rtl/vec_stream_pkg.sv
// Shared types and helpers for the vec_stream_out reader/serializer.
// Optional argmax feature is enabled by defining VEC_STREAM_ARGMAX_EN.
`timescale 1ns/1ps
package vec_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_EMIT    = 2'd3
    } state_e;

    localparam int DefVecElements  = 8;
    localparam int DefBytesPerRead = 2;

    // Counter width that never collapses to zero bits for a single-entry range.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_stream_out_if.sv
// FIFO read port plus output byte stream of vec_stream_out.
// master = serializer side, slave = FIFO/consumer side.
`timescale 1ns/1ps
interface vec_stream_out_if
    import vec_stream_pkg::*;
#(
    parameter int VecElements  = DefVecElements,
    parameter int BytesPerRead = DefBytesPerRead
);
    localparam int IdxW = idx_width(VecElements);

    logic                         rd_en;
    logic [BytesPerRead-1:0][7:0] rd_data;
    logic                         m_valid;
    logic                         m_ready;
    logic [7:0]                   m_data;
    logic [IdxW-1:0]              m_index;
    logic                         m_last;

    modport master (
        output rd_en,
        input  rd_data,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_index,
        output m_last
    );

    modport slave (
        input  rd_en,
        output rd_data,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_index,
        input  m_last
    );

endinterface

// File: rtl/argmax_tracker.sv
// Running signed-byte maximum over one streamed vector; reports the winning index.
// Only built when VEC_STREAM_ARGMAX_EN is defined.
`timescale 1ns/1ps
`ifdef VEC_STREAM_ARGMAX_EN
module argmax_tracker #(
    parameter int IdxW = 3
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            hs_i,
    input  logic            first_i,
    input  logic            last_i,
    input  logic [7:0]      data_i,
    input  logic [IdxW-1:0] index_i,
    output logic            argmax_valid_o,
    output logic [IdxW-1:0] argmax_idx_o
);
    logic signed [7:0] max_q;
    logic [IdxW-1:0]   cur_idx_q;
    logic [IdxW-1:0]   argmax_idx_q;
    logic              argmax_valid_q;
    logic              win_s;

    // Strict greater-than so ties keep the earliest index.
    assign win_s = first_i | ($signed(data_i) > max_q);

    // Running maximum and result registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            max_q          <= 8'sd0;
            cur_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            if (hs_i && win_s) begin
                max_q     <= $signed(data_i);
                cur_idx_q <= index_i;
            end
            if (hs_i && last_i) begin
                argmax_valid_q <= 1'b1;
                argmax_idx_q   <= win_s ? index_i : cur_idx_q;
            end else begin
                argmax_valid_q <= 1'b0;
            end
        end
    end

    assign argmax_valid_o = argmax_valid_q;
    assign argmax_idx_o   = argmax_idx_q;

endmodule
`endif

// File: rtl/vec_stream_out.sv
// Fetches a complete vector from a VecFIFO chunk by chunk and streams it out byte-wise.
// Define VEC_STREAM_ARGMAX_EN to add the argmax_valid/argmax_idx result ports.
`timescale 1ns/1ps
module vec_stream_out
    import vec_stream_pkg::*;
#(
    parameter int VecElements  = DefVecElements,
    parameter int BytesPerRead = DefBytesPerRead
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic vec_ready,
    output logic vec_done,
    output logic busy,
`ifdef VEC_STREAM_ARGMAX_EN
    output logic argmax_valid,
    output logic [idx_width(VecElements)-1:0] argmax_idx,
`endif
    vec_stream_out_if.master bus
);
    localparam int IdxW = idx_width(VecElements);
    localparam int PtrW = idx_width(BytesPerRead);
    localparam logic [IdxW-1:0] LastElem = IdxW'(VecElements - 1);
    localparam logic [PtrW-1:0] LastByte = PtrW'(BytesPerRead - 1);

    if ((BytesPerRead < 1) || ((VecElements % BytesPerRead) != 0)) begin : g_bad_cfg
        $error("vec_stream_out: VecElements must be a positive multiple of BytesPerRead");
    end

    state_e                       state_q,    state_d;
    logic [BytesPerRead-1:0][7:0] buf_q,      buf_d;
    logic [PtrW-1:0]              ptr_q,      ptr_d;
    logic [IdxW-1:0]              elem_q,     elem_d;
    logic                         m_valid_q,  m_valid_d;
    logic [7:0]                   m_data_q,   m_data_d;
    logic                         m_last_q,   m_last_d;
    logic                         rd_en_q,    rd_en_d;
    logic                         vec_done_q, vec_done_d;
    logic                         hs_s;
    logic [PtrW-1:0]              ptr_nxt_s;

    assign hs_s      = m_valid_q & bus.m_ready;
    assign ptr_nxt_s = ptr_q + PtrW'(1);

    // State and datapath registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            ptr_q      <= '0;
            elem_q     <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= 8'h00;
            m_last_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            vec_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            ptr_q      <= ptr_d;
            elem_q     <= elem_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_last_q   <= m_last_d;
            rd_en_q    <= rd_en_d;
            vec_done_q <= vec_done_d;
        end
    end

    // Next-state and next-output logic; rd_en is only raised once the buffer is drained.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ptr_d      = ptr_q;
        elem_d     = elem_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        rd_en_d    = 1'b0;
        vec_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vec_ready) begin
                    state_d = ST_FETCH;
                    rd_en_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                buf_d     = bus.rd_data;
                ptr_d     = '0;
                m_data_d  = bus.rd_data[0];
                m_valid_d = 1'b1;
                state_d   = ST_EMIT;
            end
            ST_EMIT: begin
                if (hs_s) begin
                    if (elem_q == LastElem) begin
                        state_d    = ST_IDLE;
                        m_valid_d  = 1'b0;
                        vec_done_d = 1'b1;
                        elem_d     = '0;
                        ptr_d      = '0;
                    end else if (ptr_q == LastByte) begin
                        state_d   = ST_FETCH;
                        rd_en_d   = 1'b1;
                        m_valid_d = 1'b0;
                        elem_d    = elem_q + IdxW'(1);
                        ptr_d     = '0;
                    end else begin
                        ptr_d    = ptr_nxt_s;
                        elem_d   = elem_q + IdxW'(1);
                        m_data_d = buf_q[ptr_nxt_s];
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
        m_last_d = (elem_d == LastElem);
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_index = elem_q;
    assign bus.m_last  = m_last_q;
    assign vec_done    = vec_done_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef VEC_STREAM_ARGMAX_EN
    argmax_tracker #(
        .IdxW (IdxW)
    ) u_argmax (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hs_i           (hs_s),
        .first_i        (elem_q == '0),
        .last_i         (m_last_q),
        .data_i         (m_data_q),
        .index_i        (elem_q),
        .argmax_valid_o (argmax_valid),
        .argmax_idx_o   (argmax_idx)
    );
`endif

endmodule

// File: tb/tb_vec_stream_out.sv
// Directed self-checking bench for vec_stream_out with a behavioural 2-byte FIFO model.
`timescale 1ns/1ps
module tb_vec_stream_out;
    import vec_stream_pkg::*;

    logic clk;
    logic rst_n;
    logic vec_ready;
    logic vec_done;
    logic busy;
`ifdef VEC_STREAM_ARGMAX_EN
    logic       argmax_valid;
    logic [2:0] argmax_idx;
`endif

    vec_stream_out_if #(.VecElements(8), .BytesPerRead(2)) bus ();

    vec_stream_out #(.VecElements(8), .BytesPerRead(2)) dut (
        .clk_in    (clk),
        .rst_in    (rst_n),
        .vec_ready (vec_ready),
        .vec_done  (vec_done),
        .busy      (busy),
`ifdef VEC_STREAM_ARGMAX_EN
        .argmax_valid (argmax_valid),
        .argmax_idx   (argmax_idx),
`endif
        .bus       (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:127];
    int         rp;
    int         fifo_base = 0;

    // FIFO model: data valid the cycle after rd_en, byte 0 = lowest address
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp <= fifo_base;
        end else if (bus.rd_en) begin
            bus.rd_data <= {mem[rp+1], mem[rp]};
            rp          <= rp + 2;
        end
    end

    logic [7:0] got_data [$];
    logic [2:0] got_idx  [$];
    logic       got_last [$];
    int         rd_cnt    = 0;
    int         vd_cnt    = 0;
    int         proto_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [2:0] prev_idx;
    logic       prev_last;

    // Monitor: records handshakes and protocol violations half a cycle ahead of the edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rd_en) rd_cnt <= rd_cnt + 1;
            if (vec_done)  vd_cnt <= vd_cnt + 1;
            if (bus.m_valid && bus.m_ready) begin
                got_data.push_back(bus.m_data);
                got_idx.push_back(bus.m_index);
                got_last.push_back(bus.m_last);
            end
            if (bus.m_valid && !bus.m_ready && bus.rd_en) proto_err <= proto_err + 1;
            if (prev_stall && (!bus.m_valid || bus.m_data !== prev_data ||
                               bus.m_index !== prev_idx || bus.m_last !== prev_last))
                proto_err <= proto_err + 1;
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
            prev_idx   <= bus.m_index;
            prev_last  <= bus.m_last;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rd_en"},    32'(bus.rd_en),   32'd0);
        chk({tag, "_m_valid"},  32'(bus.m_valid), 32'd0);
        chk({tag, "_m_data"},   32'(bus.m_data),  32'd0);
        chk({tag, "_m_index"},  32'(bus.m_index), 32'd0);
        chk({tag, "_m_last"},   32'(bus.m_last),  32'd0);
        chk({tag, "_vec_done"}, 32'(vec_done),    32'd0);
        chk({tag, "_busy"},     32'(busy),        32'd0);
    endtask

    task automatic pulse_vr();
        @(posedge clk); #1 vec_ready = 1'b1;
        @(posedge clk); #1 vec_ready = 1'b0;
    endtask

    task automatic run_vec(input int bound, input bit toggle, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(posedge clk); #1;
            if (toggle) bus.m_ready = ~bus.m_ready;
            @(negedge clk);
            if (vec_done === 1'b1) seen = 1'b1;
        end
        chk({tag, "_vec_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_items(input string tag, input int base, input logic [7:0] exp[$]);
        chk({tag, "_count"}, 32'(got_data.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i),  32'(got_data[base+i]), 32'(exp[i]));
                chk($sformatf("%s_index%0d", tag, i), 32'(got_idx[base+i]),  32'(i % 8));
                chk($sformatf("%s_last%0d", tag, i),  32'(got_last[base+i]), 32'((i % 8) == 7));
            end
        end
    endtask

    initial begin
        logic [7:0] exp [$];
        int base;
        int rd0;
        int vd0;
        bit hs_ok;

        for (int i = 0; i < 8; i++) begin
            mem[i]      = 8'(i);
            mem[8+i]    = 8'(i);
            mem[16+i]   = 8'(i);
            mem[24+i]   = 8'hFF - 8'(i);
            mem[32+i]   = 8'h10 + 8'(i);
            mem[40+i]   = 8'h20 + 8'(i);
            mem[48+i]   = 8'h30 + 8'(i);
            mem[64+i]   = 8'h80;
        end
        mem[56] = 8'h03; mem[57] = 8'hFB; mem[58] = 8'h09; mem[59] = 8'h09;
        mem[60] = 8'h80; mem[61] = 8'h02; mem[62] = 8'h00; mem[63] = 8'h01;

        rst_n = 1'b0;
        vec_ready = 1'b0;
        bus.m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic vector with latency checks
        @(posedge clk);
        rd0 = rd_cnt; vd0 = vd_cnt; base = got_data.size();
        #1 vec_ready = 1'b1; bus.m_ready = 1'b1;
        @(posedge clk); #1 vec_ready = 1'b0;
        @(negedge clk);
        chk("basic_rd_en_c1",   32'(bus.rd_en),   32'd1);
        chk("basic_busy_c1",    32'(busy),        32'd1);
        chk("basic_m_valid_c1", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        chk("basic_rd_en_c2",   32'(bus.rd_en),   32'd0);
        chk("basic_m_valid_c2", 32'(bus.m_valid), 32'd0);
        @(negedge clk);
        chk("basic_m_valid_c3", 32'(bus.m_valid), 32'd1);
        chk("basic_m_data_c3",  32'(bus.m_data),  32'd0);
        chk("basic_m_index_c3", 32'(bus.m_index), 32'd0);
        run_vec(40, 1'b0, "basic");
        chk("basic_busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'(i));
        check_items("basic", base, exp);
        chk("basic_rd_en_pulses", 32'(rd_cnt - rd0), 32'd4);
        chk("basic_vec_done_pulses", 32'(vd_cnt - vd0), 32'd1);

        // Backpressure: m_ready toggles every cycle
        bus.m_ready = 1'b0;
        rd0 = rd_cnt; base = got_data.size();
        pulse_vr();
        run_vec(80, 1'b1, "bp");
        @(posedge clk);
        check_items("bp", base, exp);
        chk("bp_rd_en_pulses", 32'(rd_cnt - rd0), 32'd4);

        // Back-to-back vectors with vec_ready held high
        @(posedge clk);
        #1 bus.m_ready = 1'b1; vec_ready = 1'b1;
        vd0 = vd_cnt; base = got_data.size();
        run_vec(60, 1'b0, "b2b_first");
        chk("b2b_busy_gap",  32'(busy), 32'd0);
        @(negedge clk);
        chk("b2b_busy_restart",  32'(busy),      32'd1);
        chk("b2b_rd_en_restart", 32'(bus.rd_en), 32'd1);
        vec_ready = 1'b0;
        run_vec(60, 1'b0, "b2b_second");
        @(posedge clk);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'(i));
        for (int i = 0; i < 8; i++) exp.push_back(8'hFF - 8'(i));
        check_items("b2b", base, exp);
        chk("b2b_vec_done_pulses", 32'(vd_cnt - vd0), 32'd2);

        // vec_ready pulsed during EMIT is ignored
        @(posedge clk);
        rd0 = rd_cnt; base = got_data.size();
        pulse_vr();
        repeat (3) @(negedge clk);
        vec_ready = 1'b1;
        @(negedge clk);
        vec_ready = 1'b0;
        run_vec(40, 1'b0, "ign");
        repeat (4) @(posedge clk);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'h10 + 8'(i));
        check_items("ign", base, exp);
        chk("ign_rd_en_pulses", 32'(rd_cnt - rd0), 32'd4);
        chk("ign_busy_after",   32'(busy),         32'd0);

        // Asynchronous reset after three handshakes
        base = got_data.size();
        pulse_vr();
        hs_ok = 1'b0;
        for (int i = 0; i < 40 && !hs_ok; i++) begin
            @(posedge clk);
            if (got_data.size() - base >= 3) hs_ok = 1'b1;
        end
        chk("rst_three_handshakes", 32'(hs_ok), 32'd1);
        #2 fifo_base = 48; rst_n = 1'b0;
        #1 chk_outputs_zero("midrst");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk);
        rd0 = rd_cnt;
        repeat (6) @(posedge clk);
        chk("midrst_no_rd_en", 32'(rd_cnt - rd0), 32'd0);
        chk("midrst_idle",     32'(busy),         32'd0);
        base = got_data.size();
        pulse_vr();
        run_vec(40, 1'b0, "recover");
        @(posedge clk);
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(8'h30 + 8'(i));
        check_items("recover", base, exp);

`ifdef VEC_STREAM_ARGMAX_EN
        pulse_vr();
        run_vec(40, 1'b0, "argmax_a");
        chk("argmax_a_valid", 32'(argmax_valid), 32'd1);
        chk("argmax_a_idx",   32'(argmax_idx),   32'd2);
        @(negedge clk);
        chk("argmax_a_valid_pulse", 32'(argmax_valid), 32'd0);
        chk("argmax_a_idx_hold",    32'(argmax_idx),   32'd2);
        pulse_vr();
        run_vec(40, 1'b0, "argmax_b");
        chk("argmax_b_valid", 32'(argmax_valid), 32'd1);
        chk("argmax_b_idx",   32'(argmax_idx),   32'd0);
`endif

        @(posedge clk);
        chk("protocol_errors", 32'(proto_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec_stream_out.md
# vec_stream_out

Reader/serializer for the output side of a `VecFIFO`. When the producer flags a complete vector, the block fetches the vector from the FIFO chunk by chunk. It then emits it one signed byte at a time on a valid/ready stream, with an element index and an end-of-vector marker. It sits between an `MVProd` output FIFO and whatever consumes results: the next layer loader, a UART dumper or a bench monitor.

## Interface
Parameters:
- `VecElements`, 8: elements per vector. Must be a multiple of `BytesPerRead`; otherwise elaboration fails.
- `BytesPerRead`, 2: bytes returned per FIFO read. Must match the attached `VecFIFO`.

Ports:
- `clk_in`  in  1  single clock.
- `rst_in`  in  1  reset, asynchronous, active-low.
- `vec_ready`  in  1  a complete vector is present in the FIFO (driven from producer `out_vector_valid`).
- `rd_en`  out  1  chunk read request to `VecFIFO`.
- `rd_data`  in  [BytesPerRead][7:0]  FIFO read data, valid the cycle after `rd_en`. Byte [0] is the lowest element index.
- `m_valid`  out  1  output byte valid.
- `m_ready`  in  1  consumer accepts the byte.
- `m_data`  out  8  signed element.
- `m_index`  out  $clog2(VecElements)  element index within the vector.
- `m_last`  out  1  marks the final element of the vector.
- `vec_done`  out  1  one-cycle pulse after the last handshake of a vector.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states:
  - IDLE: goes to FETCH when `vec_ready` is 1.
  - FETCH: `rd_en`=1 for exactly one cycle, then CAPTURE.
  - CAPTURE: registers `rd_data` into the chunk buffer, byte pointer=0, then EMIT.
  - EMIT: `m_valid`=1. On each handshake (`m_valid && m_ready`), the byte pointer and element counter advance. The last byte of a chunk goes to FETCH if chunks remain. The last byte of the vector goes to IDLE and pulses `vec_done`.
- The block holds a chunk buffer of `BytesPerRead` bytes, a byte pointer, and an element counter running from 0 to VecElements-1.
- `m_data` and `m_index` come from registered state. `m_last` = (element counter == VecElements-1).
- `vec_ready` is ignored outside IDLE. A still-high `vec_ready` in IDLE immediately starts the next vector, so back-to-back vectors are supported.
- No arithmetic is done on data. Bytes pass through bit-exact.
- The block never issues `rd_en` while the chunk buffer holds unsent bytes, so it cannot overrun the buffer. The FIFO read pointer is advanced only through `rd_en`. `wrap_rd` is not driven by this block.

## Timing
- Reset values: `rd_en`=0, `m_valid`=0, `m_data`=0, `m_index`=0, `m_last`=0, `vec_done`=0, `busy`=0, state=IDLE, all counters 0.
- Latency: `vec_ready` sampled high in IDLE at edge N gives `rd_en`=1 in cycle N+1, buffer capture at N+2, and first `m_valid` in cycle N+3.
- Chunk turnaround: the handshake on the last byte of a chunk at edge M gives the next `rd_en` in cycle M+1 and the next `m_valid` in cycle M+3.
- Sustained throughput with `m_ready` held at 1: BytesPerRead bytes every BytesPerRead+2 cycles.
- Handshake rules:
  - Once `m_valid` rises, `m_data`, `m_index` and `m_last` hold until the handshake.
  - `m_valid` never drops without a handshake.
  - `m_ready` may depend combinationally on `m_valid`.
- `vec_done` is asserted in the cycle after the `m_last` handshake, coincident with the return to IDLE.
- Reset mid-operation (asynchronous): all outputs go to their reset values immediately. A partially read vector is abandoned; recovery, such as resetting the FIFO, is the system's job.

## Configuration
- `VEC_STREAM_ARGMAX_EN` defined:
  - Adds `argmax_valid` (out, 1) and `argmax_idx` (out, $clog2(VecElements)).
  - A running signed maximum is updated on every handshake.
  - Ties keep the lowest index. Element 0 initialises the maximum.
  - `argmax_valid` pulses together with `vec_done`.
  - `argmax_idx` holds its value until the next `vec_done`. Its reset value is 0.
- `VEC_STREAM_ARGMAX_EN` not defined: the ports and logic are absent, and the stream behaviour is identical.

## Structure
- Package `vec_stream_pkg` contains the FSM state enum (IDLE, FETCH, CAPTURE, EMIT) and the index-width localparam helper.
- Sub-module `argmax_tracker` (signed byte compare, index register) is instantiated only under `VEC_STREAM_ARGMAX_EN`.

## Test plan
All scenarios use VecElements=8, BytesPerRead=2, attached to a real `VecFIFO` Depth=2.
- Basic vector: FIFO loaded with 0..7, `vec_ready` pulsed, `m_ready`=1 -> bytes 0..7, `m_index` 0..7, `m_last` only on 7, four `rd_en` pulses, one `vec_done`; first `m_valid` 3 cycles after `vec_ready`.
- Backpressure: same data, `m_ready` toggling 1/0 each cycle -> identical sequence. While `m_valid && !m_ready`, `m_data` stays stable and `rd_en` stays at 0.
- Back-to-back: two vectors (0..7, then -1..-8) and `vec_ready` held high -> 16 bytes in order, `m_last` on bytes 7 and 15, two `vec_done` pulses, `busy` low for exactly one IDLE cycle between vectors.
- Reset mid-vector: `rst_in` low after 3 handshakes -> all outputs 0 in the same cycle, state IDLE. After release there is no `rd_en` until `vec_ready`.
- Argmax (macro defined): vector 3,-5,9,9,-128,2,0,1 -> `argmax_idx`=2 with `argmax_valid` on the `vec_done` cycle. A vector of all -128 -> `argmax_idx`=0.
- Ignored request: `vec_ready` pulsed during EMIT -> no extra `rd_en` beyond VecElements/BytesPerRead per vector.
